bictr_seq_ctrl: RTL

Segment sequencer for the up/down binary counter with dynamic count-to flag. It holds a small table of counting segments, each with a preset value, a count-to value and a direction. On a start command it loads each segment into the counter in turn, enables counting, and watches the counter's tercnt flag to move to the next segment. It sits between the control/config logic and the counter instance, and owns the counter's load, cen, up_dn, data and count_to inputs.

---
 rtl/bictr_seq_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bictr_seq_ctrl.sv
// Segment sequencer for an up/down binary counter with a dynamic count-to flag.
// Walks a small table of {preset, count-to, direction, last} segments, loading
// each one into the counter and advancing when the counter reports tercnt.
module bictr_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SEG_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic [WIDTH-1:0]  cfg_cnt_to,
  input  logic              cfg_up_dn,
  input  logic              cfg_last,
  input  logic              start,
  input  logic              loop,
  input  logic              abort,
  input  logic              tercnt,
  output logic              load,
  output logic              cen,
  output logic              up_dn,
  output logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  count_to,
  output logic              busy,
  output logic [SEG_AW-1:0] seg_idx,
  output logic              seg_done,
  output logic              done
);

  localparam int NSEG = 2 ** SEG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  logic              loop_r;

  logic [WIDTH-1:0]  tbl_data  [NSEG];
  logic [WIDTH-1:0]  tbl_cnt_to[NSEG];
  logic              tbl_up_dn [NSEG];
  logic              tbl_last  [NSEG];

  logic              cur_last;
  logic [SEG_AW-1:0] nxt_idx;

  // The final table slot always ends a pass, even without its last flag set.
  always_comb begin
    cur_last = tbl_last[seg_idx] || (seg_idx == SEG_AW'(NSEG - 1));
    nxt_idx  = cur_last ? '0 : seg_idx + SEG_AW'(1);
  end

  // Segment table: writable only while the sequencer is idle, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSEG; i++) begin
        tbl_data[i]   <= '0;
        tbl_cnt_to[i] <= '0;
        tbl_up_dn[i]  <= 1'b0;
        tbl_last[i]   <= 1'b0;
      end
    end else if (cfg_we && (state == IDLE)) begin
      tbl_data[cfg_addr]   <= cfg_data;
      tbl_cnt_to[cfg_addr] <= cfg_cnt_to;
      tbl_up_dn[cfg_addr]  <= cfg_up_dn;
      tbl_last[cfg_addr]   <= cfg_last;
    end
  end

  // Sequencer FSM with registered counter controls; abort beats tercnt beats start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      loop_r   <= 1'b0;
      load     <= 1'b1;
      cen      <= 1'b0;
      up_dn    <= 1'b1;
      data     <= '0;
      count_to <= '0;
      busy     <= 1'b0;
      seg_idx  <= '0;
      seg_done <= 1'b0;
      done     <= 1'b0;
    end else begin
      seg_done <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        state <= IDLE;
        load  <= 1'b1;
        cen   <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= LOAD;
              busy     <= 1'b1;
              load     <= 1'b0;
              cen      <= 1'b0;
              seg_idx  <= '0;
              loop_r   <= loop;
              data     <= tbl_data[0];
              count_to <= tbl_cnt_to[0];
              up_dn    <= tbl_up_dn[0];
            end
          end
          LOAD: begin
            state <= RUN;
            load  <= 1'b1;
            cen   <= 1'b1;
          end
          RUN: begin
            if (tercnt) begin
              seg_done <= 1'b1;
              if (cur_last && !loop_r) begin
                state <= IDLE;
                done  <= 1'b1;
                load  <= 1'b1;
                cen   <= 1'b0;
                busy  <= 1'b0;
              end else begin
                state    <= LOAD;
                load     <= 1'b0;
                cen      <= 1'b0;
                seg_idx  <= nxt_idx;
                data     <= tbl_data[nxt_idx];
                count_to <= tbl_cnt_to[nxt_idx];
                up_dn    <= tbl_up_dn[nxt_idx];
              end
            end
          end
          default: begin
            state <= IDLE;
            load  <= 1'b1;
            cen   <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
